// File: rtl/mips32_pkg.sv
// Shared types and constants for the mips32 core and its memory-side blocks.
package mips32_pkg;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
  localparam int          IMEM_ADDR_WIDTH = 6;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } load_state_t;

endpackage

// File: rtl/imem_store.sv
// Word-addressed register array: one synchronous write port, one async read port, no reset.
// Read is 0 cycles; writes are visible from the cycle after the write edge.
module imem_store #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Instruction store filled over a valid/ready stream, then served to the core with run=1.
// Fetch is combinational; ld_ready drops in RUN and during reload, leaving beats pending.
module imem_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  reload,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  input  logic [31:0]           raddr,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  run,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow
);

  load_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  accept;
  logic                  fetch_ok;
  logic [DATA_WIDTH-1:0] rd_data;

  assign ld_ready = reset_n & (state_q == LOAD) & ~reload;
  assign accept   = ld_valid & ld_ready;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (reload) begin
      state_d = LOAD;
      wptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      wptr_d  = wptr_q + 1'b1;
      count_d = count_q + 1'b1;
      if (ld_last) begin
        state_d = RUN;
      end else if (&wptr_q) begin
        // Store is full and the program is not finished: truncate and run anyway.
        state_d = RUN;
        ovf_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= LOAD;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  imem_store #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_store (
    .clock_i (clock),
    .we_i    (accept),
    .waddr_i (wptr_q),
    .wdata_i (ld_data),
    .raddr_i (raddr[ADDR_WIDTH-1:0]),
    .rdata_o (rd_data)
  );

  // Anything outside the loaded program reads as a nop so stale store contents never leak.
  assign fetch_ok = reset_n & (state_q == RUN) & (raddr[31:ADDR_WIDTH] == '0)
                  & ({1'b0, raddr[ADDR_WIDTH-1:0]} < count_q);

  assign instr      = fetch_ok ? rd_data : DATA_WIDTH'(NOP_INSTR);
  assign run        = reset_n & (state_q == RUN);
  assign word_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stimulus queues expected observations, a negedge monitor compares them.
module tb_imem_loader;

  localparam int AW = 6;
  localparam int DW = 32;

  localparam int S_INSTR = 0;
  localparam int S_RUN   = 1;
  localparam int S_RDY   = 2;
  localparam int S_CNT   = 3;
  localparam int S_OVF   = 4;

  typedef struct {
    string       name;
    int          sig;
    logic [63:0] exp;
  } chk_t;

  logic          clock;
  logic          reset_n;
  logic          reload;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic [31:0]   raddr;
  logic [DW-1:0] instr;
  logic          run;
  logic [AW:0]   word_count;
  logic          overflow;

  chk_t chk_q[$];
  int   checks = 0;
  int   errors = 0;

  imem_loader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .reload     (reload),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .raddr      (raddr),
    .instr      (instr),
    .run        (run),
    .word_count (word_count),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: every queued expectation is compared against the DUT at the next falling edge.
  always @(negedge clock) begin
    while (chk_q.size() > 0) begin
      chk_t        c;
      logic [63:0] act;
      c = chk_q.pop_front();
      case (c.sig)
        S_INSTR: act = 64'(instr);
        S_RUN:   act = 64'(run);
        S_RDY:   act = 64'(ld_ready);
        S_CNT:   act = 64'(word_count);
        default: act = 64'(overflow);
      endcase
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s actual=%0h expected=%0h at %0t", c.name, act, c.exp, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_sig(input string n, input int s, input logic [63:0] e);
    chk_t c;
    c.name = n;
    c.sig  = s;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  task automatic fetch(input string n, input logic [31:0] a, input logic [31:0] e);
    raddr = a;
    expect_sig(n, S_INSTR, 64'(e));
    tick();
  endtask

  task automatic pulse_reload();
    reload   = 1'b1;
    ld_valid = 1'b0;
    expect_sig("reload_rdy", S_RDY, 64'd0);
    tick();
    reload = 1'b0;
  endtask

  logic [31:0] t1_words [4];
  logic [31:0] t2_words [5];

  initial begin
    t1_words[0] = 32'h2001_0005;
    t1_words[1] = 32'h2002_0007;
    t1_words[2] = 32'h0022_1820;
    t1_words[3] = 32'h0000_000D;
    t2_words[0] = 32'h3000_0001;
    t2_words[1] = 32'hDEAD_0000;
    t2_words[2] = 32'h3000_0002;
    t2_words[3] = 32'hDEAD_0001;
    t2_words[4] = 32'h3000_0003;

    reset_n  = 1'b0;
    reload   = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    raddr    = '0;
    tick();
    tick();
    expect_sig("rst_run", S_RUN, 64'd0);
    expect_sig("rst_rdy", S_RDY, 64'd0);
    expect_sig("rst_instr", S_INSTR, 64'd0);
    expect_sig("rst_cnt", S_CNT, 64'd0);
    expect_sig("rst_ovf", S_OVF, 64'd0);
    tick();
    reset_n = 1'b1;

    // 1: four-word program with ld_valid held high
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_data  = t1_words[i];
      ld_last  = (i == 3);
      expect_sig("t1_rdy", S_RDY, 64'd1);
      expect_sig("t1_run_low", S_RUN, 64'd0);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    expect_sig("t1_run", S_RUN, 64'd1);
    expect_sig("t1_cnt", S_CNT, 64'd4);
    expect_sig("t1_ovf", S_OVF, 64'd0);
    expect_sig("t1_rdy_run", S_RDY, 64'd0);
    for (int i = 0; i < 4; i++) fetch("t1_fetch", 32'(i), t1_words[i]);
    fetch("t1_fetch_oob", 32'd4, 32'h0);

    // 2: valid toggling 1,0,1,0,1(last)
    pulse_reload();
    for (int i = 0; i < 5; i++) begin
      ld_valid = (i % 2 == 0);
      ld_data  = t2_words[i];
      ld_last  = (i == 4);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    expect_sig("t2_cnt", S_CNT, 64'd3);
    expect_sig("t2_run", S_RUN, 64'd1);
    fetch("t2_fetch0", 32'd0, 32'h3000_0001);
    fetch("t2_fetch1", 32'd1, 32'h3000_0002);
    fetch("t2_fetch2", 32'd2, 32'h3000_0003);
    fetch("t2_fetch3", 32'd3, 32'h0);

    // 3: 70 beats with no last -> truncated at 64
    pulse_reload();
    for (int i = 0; i < 70; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'h1000_0000 + 32'(i);
      ld_last  = 1'b0;
      expect_sig("t3_rdy", S_RDY, (i < 64) ? 64'd1 : 64'd0);
      tick();
    end
    ld_valid = 1'b0;
    expect_sig("t3_ovf", S_OVF, 64'd1);
    expect_sig("t3_run", S_RUN, 64'd1);
    expect_sig("t3_cnt", S_CNT, 64'd64);
    fetch("t3_fetch0", 32'd0, 32'h1000_0000);
    fetch("t3_fetch63", 32'd63, 32'h1000_003F);
    fetch("t3_fetch64", 32'd64, 32'h0);

    // 4: exact fill, last on beat 64
    pulse_reload();
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'h2000_0000 + 32'(i);
      ld_last  = (i == 63);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    expect_sig("t4_ovf", S_OVF, 64'd0);
    expect_sig("t4_run", S_RUN, 64'd1);
    expect_sig("t4_cnt", S_CNT, 64'd64);
    fetch("t4_fetch63", 32'd63, 32'h2000_003F);
    fetch("t4_fetch2", 32'd2, 32'h2000_0002);

    // 5: reload from RUN, then a two-word program over stale contents
    raddr  = 32'd0;
    reload = 1'b1;
    tick();
    reload = 1'b0;
    expect_sig("t5_run_low", S_RUN, 64'd0);
    expect_sig("t5_instr_load", S_INSTR, 64'd0);
    expect_sig("t5_cnt_clr", S_CNT, 64'd0);
    tick();
    ld_valid = 1'b1;
    ld_data  = 32'hAAAA_0001;
    ld_last  = 1'b0;
    expect_sig("t5_instr_load2", S_INSTR, 64'd0);
    tick();
    ld_data = 32'hBBBB_0002;
    ld_last = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    expect_sig("t5_cnt", S_CNT, 64'd2);
    expect_sig("t5_run", S_RUN, 64'd1);
    fetch("t5_fetch0", 32'd0, 32'hAAAA_0001);
    fetch("t5_fetch1", 32'd1, 32'hBBBB_0002);
    fetch("t5_fetch2_stale", 32'd2, 32'h0);

    // 6: reload, reset and a last beat all at one edge
    reload   = 1'b1;
    reset_n  = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'hCCCC_0003;
    ld_last  = 1'b1;
    tick();
    reload   = 1'b0;
    reset_n  = 1'b1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    expect_sig("t6_run", S_RUN, 64'd0);
    expect_sig("t6_cnt", S_CNT, 64'd0);
    expect_sig("t6_ovf", S_OVF, 64'd0);
    expect_sig("t6_rdy", S_RDY, 64'd1);
    tick();
    ld_valid = 1'b1;
    ld_data  = 32'h1234_5678;
    ld_last  = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    expect_sig("t6_cnt1", S_CNT, 64'd1);
    fetch("t6_fetch0", 32'd0, 32'h1234_5678);
    fetch("t6_fetch_hi", 32'h0000_0040, 32'h0);
    fetch("t6_fetch_top", 32'h8000_0000, 32'h0);

    tick();
    tick();
    if (chk_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", chk_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
